// File: rtl/fp_mul_arbiter_if.sv
// Requester-side and multiplier-side buses for fp_mul_arbiter.
// Latency: none (wiring only). Backpressure: carried by req_ready/rsp_ready.
// Requester operand slice i lives at bits [32*i +: 32] of req_a/req_b.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_nan;
    logic                  rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_nan, rsp_timeout
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_nan, rsp_timeout
    );
endinterface

interface fp_mul_if;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_en;
    logic [31:0] mul_result;
    logic        mul_ready;
    logic        mul_nan;

    modport master (
        output mul_a, mul_b, mul_en,
        input  mul_result, mul_ready, mul_nan
    );
    modport slave (
        input  mul_a, mul_b, mul_en,
        output mul_result, mul_ready, mul_nan
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP multiplier among NUM_REQ requesters; MUL_TIMEOUT_EN adds a WAIT timeout.
// Latency: accept at T, mul_en on T+1..T+EN_CYCLES, rsp_valid the cycle after mul_ready is sampled.
// Backpressure: one op in flight; req_ready only in IDLE; RESP holds until the granted rsp_ready.
module fp_mul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int EN_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    fp_mul_arbiter_if.slave  req_bus,
    fp_mul_if.master         mul_bus,
    output logic             busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, grant_q, grant_idx;
    logic          grant_found;
    logic [1:0]    en_cnt;
    logic [31:0]   mul_a_q, mul_b_q, result_q;
    logic          nan_q, timeout_q;
    logic          accept, timed_out, rsp_done;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_v;
        grant_found = 1'b0;
        grant_idx   = ptr;
        idx         = 0;
        idx_v       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = IW'(idx);
            if (!grant_found && req_bus.req_valid[idx_v]) begin
                grant_found = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

    assign accept   = (state == S_IDLE) && grant_found;
    assign rsp_done = (state == S_RESP) && req_bus.rsp_ready[grant_q];

`ifdef MUL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Held at zero outside WAIT so every WAIT entry starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                to_cnt <= '0;
        else if (state != S_WAIT)  to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
    end

    assign timed_out = (state == S_WAIT) && !mul_bus.mul_ready &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: if (en_cnt == 2'(EN_CYCLES - 1)) state_nxt = S_WAIT;
            S_WAIT:  if (mul_bus.mul_ready || timed_out) state_nxt = S_RESP;
            S_RESP:  if (rsp_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            grant_q   <= '0;
            en_cnt    <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            result_q  <= '0;
            nan_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                mul_a_q <= req_bus.req_a[grant_idx*32 +: 32];
                mul_b_q <= req_bus.req_b[grant_idx*32 +: 32];
                grant_q <= grant_idx;
                en_cnt  <= '0;
            end
            if (state == S_ISSUE) en_cnt <= en_cnt + 1'b1;
            // A real Ready beats a timeout landing on the same cycle.
            if (state == S_WAIT) begin
                if (mul_bus.mul_ready) begin
                    result_q  <= mul_bus.mul_result;
                    nan_q     <= mul_bus.mul_nan;
                    timeout_q <= 1'b0;
                end else if (timed_out) begin
                    result_q  <= 32'h7FC0_0000;
                    nan_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
            if (rsp_done) ptr <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign req_bus.req_ready   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign req_bus.rsp_valid   = (state == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign req_bus.rsp_result  = result_q;
    assign req_bus.rsp_nan     = nan_q;
    assign req_bus.rsp_timeout = timeout_q;
    assign mul_bus.mul_a       = mul_a_q;
    assign mul_bus.mul_b       = mul_b_q;
    assign mul_bus.mul_en      = (state == S_ISSUE);
    assign busy                = (state != S_IDLE);
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural multiplier plus scoreboard of expected responses.
module tb_fp_mul_arbiter;
    localparam int NR  = 4;
    localparam int ENC = 2;
    localparam int TO  = 16;

    logic clk;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic model_hang;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        nan;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] op_a [NR];
    logic [31:0] op_b [NR];
    logic [31:0] m_a, m_b;
    logic        m_pend;
    int          m_cnt;

    fp_mul_arbiter_if #(.NUM_REQ(NR)) req_bus ();
    fp_mul_if                         mul_bus ();

    fp_mul_arbiter #(.NUM_REQ(NR), .EN_CYCLES(ENC), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_bus (req_bus),
        .mul_bus (mul_bus),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference products for the operand pairs used below.
    function automatic logic [32:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] k;
        logic [32:0] r;
        k = {a, b};
        case (k)
            64'h3F800000_40000000: r = {1'b0, 32'h40000000};
            64'h3FC00000_40200000: r = {1'b0, 32'h40700000};
            64'h40000000_40400000: r = {1'b0, 32'h40C00000};
            64'h40400000_40800000: r = {1'b0, 32'h41400000};
            64'h40A00000_3F000000: r = {1'b0, 32'h40200000};
            64'h7FC00000_3F800000: r = {1'b1, 32'h7FC00000};
            64'hFF800000_3F800000: r = {1'b0, 32'hFF800000};
            default:               r = {1'b0, 32'h0BAD0BAD};
        endcase
        return r;
    endfunction

    // Multiplier model: Ready drops on En, rises 3 cycles after En ends.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_bus.mul_ready  <= 1'b0;
            mul_bus.mul_result <= '0;
            mul_bus.mul_nan    <= 1'b0;
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (mul_bus.mul_en) begin
            mul_bus.mul_ready <= 1'b0;
            m_a    <= mul_bus.mul_a;
            m_b    <= mul_bus.mul_b;
            m_pend <= 1'b1;
            m_cnt  <= 0;
        end else if (m_pend && !model_hang) begin
            if (m_cnt == 2) begin
                mul_bus.mul_ready <= 1'b1;
                {mul_bus.mul_nan, mul_bus.mul_result} <= mul_ref(m_a, m_b);
                m_pend <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_bus.req_a[i*32 +: 32] = a;
        req_bus.req_b[i*32 +: 32] = b;
        req_bus.req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_hang = 1'b0;
        req_bus.req_valid = '0;
        req_bus.req_a     = '0;
        req_bus.req_b     = '0;
        req_bus.rsp_ready = '0;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, mul_bus.mul_en, req_bus.req_ready, req_bus.rsp_valid, req_bus.rsp_nan, req_bus.rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b en=%b req_ready=%b rsp_valid=%b nan=%b to=%b, required all 0",
                     busy, mul_bus.mul_en, req_bus.req_ready, req_bus.rsp_valid, req_bus.rsp_nan, req_bus.rsp_timeout);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mul_bus.mul_a, mul_bus.mul_b, req_bus.rsp_result} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: mul_a=%h mul_b=%h rsp_result=%h, required 0",
                     mul_bus.mul_a, mul_bus.mul_b, req_bus.rsp_result);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, req_bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b req_ready=%b, required 0", busy, req_bus.req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int rdy_n, en_n, rdy_at, en_at;
        bit acc, done;
        logic [32:0] r;
        logic [NR-1:0] oh;
        rdy_n = 0; en_n = 0; rdy_at = -1; en_at = -1; acc = 0; done = 0;
        req_bus.rsp_ready = '1;
        set_req(0, 32'h3F800000, 32'h40000000);
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (acc) req_bus.req_valid[0] = 1'b0;
            if (req_bus.req_ready != '0) begin
                rdy_n++;
                if (rdy_at < 0) rdy_at = cyc;
                checks++;
                if (req_bus.req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_grant: req_ready=%b, required 0001", req_bus.req_ready);
                end
                if (!acc) begin
                    r = mul_ref(32'h3F800000, 32'h40000000);
                    sb.push_back('{0, r[31:0], r[32], 1'b0});
                end
                acc = 1;
            end
            if (mul_bus.mul_en) begin
                en_n++;
                if (en_at < 0) en_at = cyc;
                checks++;
                if ({mul_bus.mul_a, mul_bus.mul_b} !== {32'h3F800000, 32'h40000000}) begin
                    errors++;
                    $display("FAIL single_operands: a=%h b=%h, required 3f800000 40000000", mul_bus.mul_a, mul_bus.mul_b);
                end
            end
            if (req_bus.rsp_valid != '0) begin
                done = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_rsp: unexpected rsp_valid=%b", req_bus.rsp_valid);
                end else begin
                    e = sb.pop_front();
                    oh = NR'(1) << e.idx;
                    if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout} !== {oh, e.res, e.nan, e.to}) begin
                        errors++;
                        $display("FAIL single_rsp: valid=%b res=%h nan=%b to=%b, required valid=%b res=%h nan=%b to=%b",
                                 req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout, oh, e.res, e.nan, e.to);
                    end
                end
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL single_timeout: no response seen, required one within 60 cycles");
        end
        checks++;
        if (rdy_n != 1 || en_n != ENC || en_at != rdy_at + 1) begin
            errors++;
            $display("FAIL single_timing: ready_cycles=%0d en_cycles=%0d en_offset=%0d, required 1 %0d 1",
                     rdy_n, en_n, en_at - rdy_at, ENC);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, req_bus.rsp_valid} !== '0) begin
            errors++;
            $display("FAIL single_done: busy=%b rsp_valid=%b, required 0", busy, req_bus.rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int g_cnt, r_cnt, k;
        logic [32:0] r;
        logic [NR-1:0] oh;
        g_cnt = 0; r_cnt = 0;
        do_reset();
        req_bus.rsp_ready = '1;
        for (int i = 0; i < NR; i++) set_req(i, op_a[i], op_b[i]);
        for (int cyc = 0; cyc < 300 && r_cnt < 5; cyc++) begin
            #1;
            if (req_bus.req_ready != '0) begin
                k = g_cnt % NR;
                oh = NR'(1) << k;
                checks++;
                if (req_bus.req_ready !== oh) begin
                    errors++;
                    $display("FAIL rr_grant%0d: req_ready=%b, required %b", g_cnt, req_bus.req_ready, oh);
                end
                r = mul_ref(op_a[k], op_b[k]);
                sb.push_back('{k, r[31:0], r[32], 1'b0});
                g_cnt++;
            end
            if (req_bus.rsp_valid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_rsp: unexpected rsp_valid=%b", req_bus.rsp_valid);
                end else begin
                    e = sb.pop_front();
                    oh = NR'(1) << e.idx;
                    if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan} !== {oh, e.res, e.nan}) begin
                        errors++;
                        $display("FAIL rr_rsp%0d: valid=%b res=%h nan=%b, required valid=%b res=%h nan=%b",
                                 r_cnt, req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, oh, e.res, e.nan);
                    end
                end
                r_cnt++;
                if (r_cnt == 5) req_bus.req_valid = '0;
            end
            @(negedge clk);
        end
        checks++;
        if (g_cnt != 5 || r_cnt != 5) begin
            errors++;
            $display("FAIL rr_count: grants=%0d responses=%0d, required 5 5", g_cnt, r_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit acc, seen;
        logic [32:0] r;
        acc = 0; seen = 0;
        req_bus.rsp_ready = 4'b1101;
        set_req(1, 32'h3FC00000, 32'h40200000);
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (acc) begin
                req_bus.req_valid[1] = 1'b0;
                set_req(0, op_a[0], op_b[0]);
                set_req(3, op_a[3], op_b[3]);
            end
            if (req_bus.req_ready != '0 && !acc) begin
                checks++;
                if (req_bus.req_ready !== 4'b0010) begin
                    errors++;
                    $display("FAIL bp_grant: req_ready=%b, required 0010", req_bus.req_ready);
                end
                r = mul_ref(32'h3FC00000, 32'h40200000);
                sb.push_back('{1, r[31:0], r[32], 1'b0});
                acc = 1;
            end
            if (req_bus.rsp_valid != '0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_timeout: response seen=%0d queued=%0d, required 1 1", seen, sb.size());
        end else begin
            e = sb.pop_front();
        end
        for (int h = 0; h < 10; h++) begin
            checks++;
            if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout, req_bus.req_ready, mul_bus.mul_en}
                !== {4'b0010, e.res, e.nan, 1'b0, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b res=%h nan=%b to=%b req_ready=%b en=%b, required 0010 %h %b 0 0000 0",
                         h, req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout,
                         req_bus.req_ready, mul_bus.mul_en, e.res, e.nan);
            end
            @(negedge clk);
            #1;
        end
        req_bus.rsp_ready[1] = 1'b1;
        @(negedge clk);
        #1;
        // Pointer moved to 2, so requester 3 beats requester 0.
        checks++;
        if ({req_bus.rsp_valid, req_bus.req_ready} !== {4'b0000, 4'b1000}) begin
            errors++;
            $display("FAIL bp_next: rsp_valid=%b req_ready=%b, required 0000 1000", req_bus.rsp_valid, req_bus.req_ready);
        end
        req_bus.req_valid[0] = 1'b0;
        r = mul_ref(op_a[3], op_b[3]);
        sb.push_back('{3, r[31:0], r[32], 1'b0});
        seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            #1;
            req_bus.req_valid[3] = 1'b0;
            if (req_bus.rsp_valid != '0) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_req3: response seen=%0d queued=%0d, required 1 1", seen, sb.size());
        end else begin
            e = sb.pop_front();
            if ({req_bus.rsp_valid, req_bus.rsp_result} !== {4'b1000, e.res}) begin
                errors++;
                $display("FAIL bp_req3: valid=%b res=%h, required 1000 %h", req_bus.rsp_valid, req_bus.rsp_result, e.res);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_nan_inf();
        logic [31:0] ta [2];
        logic [32:0] r;
        logic [NR-1:0] oh;
        bit acc, seen;
        ta[0] = 32'h7FC00000;
        ta[1] = 32'hFF800000;
        req_bus.rsp_ready = '1;
        for (int t = 0; t < 2; t++) begin
            acc = 0; seen = 0;
            set_req(t, ta[t], 32'h3F800000);
            for (int cyc = 0; cyc < 60; cyc++) begin
                #1;
                if (acc) req_bus.req_valid[t] = 1'b0;
                if (req_bus.req_ready != '0 && !acc) begin
                    r = mul_ref(ta[t], 32'h3F800000);
                    sb.push_back('{t, r[31:0], r[32], 1'b0});
                    acc = 1;
                end
                if (req_bus.rsp_valid != '0) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!seen || sb.size() == 0) begin
                errors++;
                $display("FAIL special%0d_timeout: response seen=%0d queued=%0d, required 1 1", t, seen, sb.size());
            end else begin
                e = sb.pop_front();
                oh = NR'(1) << e.idx;
                if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout} !== {oh, e.res, e.nan, 1'b0}) begin
                    errors++;
                    $display("FAIL special%0d: valid=%b res=%h nan=%b to=%b, required %b %h %b 0",
                             t, req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout, oh, e.res, e.nan);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, en_seen, seen;
        int bad;
        logic [32:0] r;
        acc = 0; en_seen = 0; seen = 0; bad = 0;
        req_bus.rsp_ready = '1;
        set_req(0, 32'h40000000, 32'h40400000);
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (acc) req_bus.req_valid[0] = 1'b0;
            if (req_bus.req_ready != '0) acc = 1;
            if (mul_bus.mul_en) en_seen = 1;
            if (en_seen && !mul_bus.mul_en) break;
            @(negedge clk);
        end
        model_hang = 1'b1;
        checks++;
        if ({busy, mul_bus.mul_a} !== {1'b1, 32'h40000000}) begin
            errors++;
            $display("FAIL mid_wait: busy=%b mul_a=%h, required 1 40000000", busy, mul_bus.mul_a);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busy, mul_bus.mul_en, req_bus.req_ready, req_bus.rsp_valid, req_bus.rsp_nan, req_bus.rsp_timeout,
             mul_bus.mul_a, mul_bus.mul_b, req_bus.rsp_result} !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b en=%b rsp_valid=%b a=%h b=%h res=%h, required all 0",
                     busy, mul_bus.mul_en, req_bus.rsp_valid, mul_bus.mul_a, mul_bus.mul_b, req_bus.rsp_result);
        end
        @(negedge clk);
        reset = 1'b1;
        model_hang = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (busy || req_bus.rsp_valid != '0 || mul_bus.mul_en) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_abandon: %0d cycles with activity after reset, required 0", bad);
        end
        acc = 0;
        set_req(2, op_a[2], op_b[2]);
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (acc) req_bus.req_valid[2] = 1'b0;
            if (req_bus.req_ready != '0 && !acc) begin
                checks++;
                if (req_bus.req_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL mid_grant: req_ready=%b, required 0100", req_bus.req_ready);
                end
                r = mul_ref(op_a[2], op_b[2]);
                sb.push_back('{2, r[31:0], r[32], 1'b0});
                acc = 1;
            end
            if (req_bus.rsp_valid != '0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || sb.size() == 0) begin
            errors++;
            $display("FAIL mid_rsp: response seen=%0d queued=%0d, required 1 1", seen, sb.size());
        end else begin
            e = sb.pop_front();
            if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan} !== {4'b0100, e.res, e.nan}) begin
                errors++;
                $display("FAIL mid_rsp: valid=%b res=%h nan=%b, required 0100 %h %b",
                         req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, e.res, e.nan);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit acc, en_seen;
        int wait_n, bad;
        acc = 0; en_seen = 0; wait_n = 0; bad = 0;
        model_hang = 1'b1;
        req_bus.rsp_ready = '1;
        set_req(1, 32'h3FC00000, 32'h40200000);
`ifdef MUL_TIMEOUT_EN
        begin
            bit seen;
            seen = 0;
            for (int cyc = 0; cyc < 100; cyc++) begin
                #1;
                if (acc) req_bus.req_valid[1] = 1'b0;
                if (req_bus.req_ready != '0 && !acc) begin
                    sb.push_back('{1, 32'h7FC00000, 1'b1, 1'b1});
                    acc = 1;
                end
                if (mul_bus.mul_en) en_seen = 1;
                if (req_bus.rsp_valid != '0) begin
                    seen = 1;
                    break;
                end
                if (en_seen && busy && !mul_bus.mul_en) wait_n++;
                @(negedge clk);
            end
            checks++;
            if (wait_n != TO) begin
                errors++;
                $display("FAIL to_cycles: wait cycles=%0d, required %0d", wait_n, TO);
            end
            checks++;
            if (!seen || sb.size() == 0) begin
                errors++;
                $display("FAIL to_rsp: response seen=%0d queued=%0d, required 1 1", seen, sb.size());
            end else begin
                e = sb.pop_front();
                if ({req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout} !== {4'b0010, e.res, e.nan, e.to}) begin
                    errors++;
                    $display("FAIL to_rsp: valid=%b res=%h nan=%b to=%b, required 0010 %h %b %b",
                             req_bus.rsp_valid, req_bus.rsp_result, req_bus.rsp_nan, req_bus.rsp_timeout, e.res, e.nan, e.to);
                end
            end
            @(negedge clk);
        end
`else
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (acc) req_bus.req_valid[1] = 1'b0;
            if (req_bus.req_ready != '0) acc = 1;
            if (mul_bus.mul_en) en_seen = 1;
            if (en_seen && (!busy || req_bus.rsp_valid != '0 || req_bus.rsp_timeout)) bad++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (!en_seen || bad != 0 || !busy) begin
            errors++;
            $display("FAIL hang_busy: issued=%0d bad_cycles=%0d busy=%b, required 1 0 1", en_seen, bad, busy);
        end
        do_reset();
`endif
        model_hang = 1'b0;
    endtask

    initial begin
        op_a[0] = 32'h40000000; op_b[0] = 32'h40400000;
        op_a[1] = 32'h3FC00000; op_b[1] = 32'h40200000;
        op_a[2] = 32'h40400000; op_b[2] = 32'h40800000;
        op_a[3] = 32'h40A00000; op_b[3] = 32'h3F000000;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_nan_inf();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-precision Multiplier between NUM_REQ requesters.
- Accepts one operand pair at a time and drives the Multiplier's A/B/En inputs.
- Waits for Multiplier Ready, then returns Result and NaN to the granted requester over a valid/ready response handshake.
- Sits between the requester ports and the Multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- EN_CYCLES, 2, number of cycles mul_en is held high per operation (1..4).
- TIMEOUT_CYCLES, 64, number of WAIT cycles before timeout; used only with MUL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  operand B; slice i belongs to requester i.
- rsp_valid  out  NUM_REQ  one-hot response valid to the granted requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  32  shared result bus.
- rsp_nan  out  1  NaN flag for the current response.
- rsp_timeout  out  1  Multiplier timeout flag for the current response.
- mul_a  out  32  to Multiplier A.
- mul_b  out  32  to Multiplier B.
- mul_en  out  1  to Multiplier En.
- mul_result  in  32  from Multiplier Result.
- mul_ready  in  1  from Multiplier Ready.
- mul_nan  in  1  from Multiplier NaN.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, applied asynchronously):
  - state IDLE, round-robin pointer 0.
  - All outputs 0, including mul_a, mul_b, rsp_result.
  - Reset mid-operation abandons the operation. mul_en drops immediately. No response is produced for the abandoned operation.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search req_valid starting at the pointer and wrapping modulo NUM_REQ. The first set bit is the grant g.
  - req_ready[g] is asserted combinationally, in IDLE only.
  - Handshake occurs when req_valid[g] and req_ready[g] are both 1 at a clock edge. On that edge, latch req_a[g]/req_b[g] into mul_a/mul_b, latch g, go to ISSUE.
  - Dropping req_valid before acceptance is legal and has no effect.
- ISSUE:
  - mul_en = 1 for exactly EN_CYCLES cycles, then WAIT.
  - mul_a/mul_b stay stable from ISSUE until RESP is exited.
  - mul_ready is ignored during ISSUE, because the Multiplier clears Ready on En.
- WAIT:
  - mul_en = 0.
  - On the first cycle with mul_ready = 1: capture mul_result into rsp_result and mul_nan into rsp_nan, clear rsp_timeout, go to RESP.
- RESP:
  - rsp_valid[g] = 1; rsp_result, rsp_nan and rsp_timeout are held stable.
  - On rsp_ready[g] = 1: clear rsp_valid, set pointer = (g+1) mod NUM_REQ, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
  - The next grant is possible at the earliest in the first IDLE cycle; this is a one-cycle bubble.
- Latency: handshake at edge T, mul_en high on cycles T+1..T+EN_CYCLES, WAIT from T+EN_CYCLES+1, rsp_valid the cycle after mul_ready is sampled.
- Only one operation is outstanding at a time. Requests arriving during ISSUE/WAIT/RESP wait; req_ready stays 0.
- Fairness: with all requesters continuously valid, grants follow the cyclic order 0,1,...,NUM_REQ-1,0.
- The operand path carries no arithmetic. Results are passed through bit-exact; the sign of zero, inf and NaN payloads are not altered.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT entry and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mul_ready, go to RESP with rsp_result = 32'h7FC00000, rsp_nan = 1, rsp_timeout = 1.
  - If mul_ready and timeout occur in the same cycle, mul_ready wins.
- Undefined:
  - No counter; WAIT lasts indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Single request, req0: A=3F800000, B=40000000; model Ready 3 cycles after En with Result=40000000 -> req_ready[0] for 1 cycle, mul_en high for 2 cycles with mul_a/mul_b equal to the operands, rsp_valid[0] with 40000000 and nan=0.
- All four requesters continuously valid, each with distinct operands (req1: 3FC00000 x 40200000 -> 40700000) -> grant order 0,1,2,3,0; each response appears only on its own rsp_valid bit with the correct result.
- rsp_ready[1] held low for 10 cycles in RESP -> rsp_valid[1], rsp_result and flags stay stable; no req_ready asserted; mul_en stays 0.
- Model returns NaN=1 with Result=7FC00000 -> rsp_nan=1, rsp_result=7FC00000. Model returns FF800000 -> passed through unchanged with nan=0.
- reset driven low during WAIT -> all outputs 0 without waiting for a clock edge. After release, req2 is the only request and is served first (pointer = 0 scan), with a correct result.
- MUL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, model never raises Ready -> after 16 WAIT cycles rsp_valid with 7FC00000, nan=1, timeout=1. Macro undefined -> busy stays 1 and no response is produced.
